// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative RV64 M-extension divider.
package div_unit_pkg;

    localparam int unsigned DIV_XLEN = 64;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and word forms, with
// valid/ready handshakes on both sides and a fast path for /0 and overflow.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    div_state_e      state;
    logic            rem_sel_q;
    logic            word_q;
    logic            neg_q;
    logic            neg_r;
    logic [6:0]      cnt;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] divisor;

    logic            is_signed;
    logic            is_rem;
    logic            sign_a;
    logic            sign_b;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] eff_a;
    logic [XLEN-1:0] eff_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] min_neg;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] sel;
    logic [XLEN-1:0] fix_val;

    assign in_ready = (state == ST_IDLE);

    always_comb begin
        is_signed = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
        is_rem    = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
        if (word) begin
            eff_a   = {{(XLEN-32){is_signed & a[31]}}, a[31:0]};
            eff_b   = {{(XLEN-32){is_signed & b[31]}}, b[31:0]};
            min_neg = {{(XLEN-31){1'b1}}, {31{1'b0}}};
        end else begin
            eff_a   = a;
            eff_b   = b;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
        sign_a   = is_signed & eff_a[XLEN-1];
        sign_b   = is_signed & eff_b[XLEN-1];
        mag_a    = sign_a ? -eff_a : eff_a;
        mag_b    = sign_b ? -eff_b : eff_b;
        div_zero = (eff_b == '0);
        ovf      = is_signed && (eff_b == '1) && (eff_a == min_neg);
    end

    // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
    always_comb begin
        trial = {rem, quo[XLEN-1]} - {1'b0, divisor};
    end

    always_comb begin
        q_fix   = neg_q ? -quo : quo;
        r_fix   = neg_r ? -rem : rem;
        sel     = rem_sel_q ? r_fix : q_fix;
        fix_val = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rem_sel_q <= 1'b0;
            word_q    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        rem_sel_q <= is_rem;
                        word_q    <= word;
                        divisor   <= mag_b;
                        // Fast path preloads final quo/rem with no sign fix-up and
                        // lets FIX do selection and word extension in one edge.
                        if (div_zero || ovf) begin
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            quo   <= div_zero ? '1 : eff_a;
                            rem   <= div_zero ? eff_a : '0;
                            state <= ST_FIX;
                        end else begin
                            neg_q <= sign_a ^ sign_b;
                            neg_r <= sign_a;
                            rem   <= '0;
                            quo   <= word ? (mag_a << 32) : mag_a;
                            cnt   <= word ? 7'd31 : 7'd63;
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem <= trial[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : trial[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], ~trial[XLEN]};
                    cnt <= cnt - 7'd1;
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result    <= fix_val;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, results, back-pressure,
// flush and asynchronous reset behaviour.
module tb_div_unit;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic         word = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;

    div_unit #(.XLEN(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .word      (word),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one request, then count edges until out_valid; leaves the unit in DONE.
    task automatic run_op(input string tag, input logic [1:0] o, input logic w,
                          input logic [63:0] xa, input logic [63:0] xb,
                          input logic [63:0] exp, input int exp_lat);
        int n;
        @(negedge clk);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        op = o; word = w; a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 64'h1234_5678_9ABC_DEF0;
        b = 64'h0000_0000_0000_0003;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_result"}, result, exp);
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int spurious;
        logic [63:0] held;

        #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("div_m7_2", 2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        release_result("div_m7_2");
        run_op("rem_m7_2", 2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        release_result("rem_m7_2");

        run_op("divu_by0", 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        release_result("divu_by0");
        run_op("remu_by0", 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        release_result("remu_by0");
        run_op("remu_by0_b", 2'b11, 1'b0, 64'h0000_0000_0000_1234, 64'd0, 64'h0000_0000_0000_1234, 1);
        release_result("remu_by0_b");

        run_op("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        release_result("div_ovf");
        run_op("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        release_result("rem_ovf");

        run_op("divuw", 2'b01, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        release_result("divuw");
        run_op("remw_ovf", 2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1);
        release_result("remw_ovf");
        run_op("divw_m100_7", 2'b00, 1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 33);
        release_result("divw_m100_7");

        run_op("bp_divu", 2'b01, 1'b0, 64'd1000, 64'd3, 64'd333, 65);
        held = result;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) spurious++;
        end
        check("bp_hold_stable", 64'(spurious), 64'd0);
        check("bp_hold_result", result, 64'd333);
        release_result("bp");
        run_op("bp_next_remu", 2'b11, 1'b0, 64'd1000, 64'd3, 64'd1, 65);
        release_result("bp_next");

        @(negedge clk);
        op = 2'b01; word = 1'b0; a = 64'd500; b = 64'd9; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        spurious = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious++;
        end
        check("flush_no_result", 64'(spurious), 64'd0);

        @(negedge clk);
        op = 2'b00; word = 1'b0; a = 64'd500; b = 64'd9; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious++;
        end
        check("arst_no_result", 64'(spurious), 64'd0);

        run_op("divu_100_7", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        release_result("divu_100_7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
